// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator: pixel/line counters plus zero-skew
// blank, sync, frame/vblank strobes and a wrapping frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FCW     = 16;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_VIS + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_VIS + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  localparam logic [CW-1:0] X_MAX = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_TOTAL - 1);

  logic [CW-1:0]  x_q, x_d;
  logic [CW-1:0]  y_q, y_d;
  logic           blank_q, blank_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           frame_start_q, frame_start_d;
  logic           vblank_start_q, vblank_start_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  // Next raster position; all flags are decoded from it so they land with it.
  always_comb begin
    x_d         = x_q + CW'(1);
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    if (x_q == X_MAX) begin
      x_d = '0;
      if (y_q == Y_MAX) begin
        y_d         = '0;
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end else begin
        y_d = y_q + CW'(1);
      end
    end

    blank_d        = (x_d < CW'(H_VIS)) && (y_d < CW'(V_VIS));
    hs_d           = !((x_d >= CW'(HS_BEG)) && (x_d < CW'(HS_END)));
    vs_d           = !((y_d >= CW'(VS_BEG)) && (y_d < CW'(VS_END)));
    frame_start_d  = (x_d == '0) && (y_d == '0);
    vblank_start_d = (x_d == '0) && (y_d == CW'(V_VIS));
  end

  // Reset parks the raster on the last pixel so release starts a fresh frame.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_q            <= X_MAX;
      y_q            <= Y_MAX;
      blank_q        <= 1'b0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      blank_q        <= blank_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign DrawX        = x_q;
  assign DrawY        = y_q;
  assign blank        = blank_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing
// instance, each scored every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int HV_D = 640, HF_D = 16, HS_D = 96, HB_D = 48;
  localparam int VV_D = 480, VF_D = 10, VS_D = 2,  VB_D = 33;
  localparam int HT_D = HV_D + HF_D + HS_D + HB_D;
  localparam int VT_D = VV_D + VF_D + VS_D + VB_D;

  localparam int HV_S = 16, HF_S = 2, HS_S = 4, HB_S = 3;
  localparam int VV_S = 10, VF_S = 2, VS_S = 2, VB_S = 3;
  localparam int HT_S = HV_S + HF_S + HS_S + HB_S;
  localparam int VT_S = VV_S + VF_S + VS_S + VB_S;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_def, rst_sml;
  logic [9:0]  dx_def, dy_def, dx_sml, dy_sml;
  logic        bl_def, hs_def, vs_def, fs_def, vb_def;
  logic        bl_sml, hs_sml, vs_sml, fs_sml, vb_sml;
  logic [15:0] fc_def, fc_sml;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset_n(rst_def), .DrawX(dx_def), .DrawY(dy_def),
    .blank(bl_def), .hs(hs_def), .vs(vs_def), .frame_start(fs_def),
    .vblank_start(vb_def), .frame_count(fc_def)
  );

  vga_timing_gen #(
    .H_VIS(HV_S), .H_FP(HF_S), .H_SYNC(HS_S), .H_BP(HB_S),
    .V_VIS(VV_S), .V_FP(VF_S), .V_SYNC(VS_S), .V_BP(VB_S)
  ) u_sml (
    .vga_clk(clk), .reset_n(rst_sml), .DrawX(dx_sml), .DrawY(dy_sml),
    .blank(bl_sml), .hs(hs_sml), .vs(vs_sml), .frame_start(fs_sml),
    .vblank_start(vb_sml), .frame_count(fc_sml)
  );

  // Raster model: position advances through a row-major walk of the frame.
  int mx_def, my_def, mfc_def, mx_sml, my_sml, mfc_sml;
  bit mrst_def, mrst_sml;
  bit preload_sml = 1'b0;

  always @(posedge clk) begin
    if (!rst_def) begin
      mx_def = HT_D - 1; my_def = VT_D - 1; mfc_def = 0; mrst_def = 1'b1;
    end else begin
      mrst_def = 1'b0;
      if (mx_def == HT_D - 1 && my_def == VT_D - 1) mfc_def = (mfc_def + 1) % 65536;
      my_def = ((my_def * HT_D + mx_def + 1) / HT_D) % VT_D;
      mx_def = (mx_def + 1) % HT_D;
    end
    if (!rst_sml) begin
      mx_sml = HT_S - 1; my_sml = VT_S - 1; mfc_sml = 0; mrst_sml = 1'b1;
    end else begin
      mrst_sml = 1'b0;
      if (preload_sml) mfc_sml = 65535;
      if (mx_sml == HT_S - 1 && my_sml == VT_S - 1) mfc_sml = (mfc_sml + 1) % 65536;
      my_sml = ((my_sml * HT_S + mx_sml + 1) / HT_S) % VT_S;
      mx_sml = (mx_sml + 1) % HT_S;
    end
  end

  function automatic logic [4:0] exp_flags(int x, int y, int hv, int hf, int hsy,
                                           int vv, int vf, int vsy);
    logic bl, h, v, f, b;
    bl = (x < hv) && (y < vv);
    h  = !((x >= hv + hf) && (x < hv + hf + hsy));
    v  = !((y >= vv + vf) && (y < vv + vf + vsy));
    f  = (x == 0) && (y == 0);
    b  = (x == 0) && (y == vv);
    return {bl, h, v, f, b};
  endfunction

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  fc_skip_sml = 1'b0;
  int  cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One cycle: step to the sampling edge, then score both instances.
  task automatic tick();
    logic [4:0] ef;
    @(negedge clk);
    cyc++;
    ef = mrst_def ? 5'b01100 : exp_flags(mx_def, my_def, HV_D, HF_D, HS_D, VV_D, VF_D, VS_D);
    chk("sb_def_raster", {7'd0, dx_def, dy_def, bl_def, hs_def, vs_def, fs_def, vb_def},
        {7'd0, 10'(mx_def), 10'(my_def), ef});
    chk("sb_def_fcount", {16'd0, fc_def}, 32'(mfc_def));
    ef = mrst_sml ? 5'b01100 : exp_flags(mx_sml, my_sml, HV_S, HF_S, HS_S, VV_S, VF_S, VS_S);
    chk("sb_sml_raster", {7'd0, dx_sml, dy_sml, bl_sml, hs_sml, vs_sml, fs_sml, vb_sml},
        {7'd0, 10'(mx_sml), 10'(my_sml), ef});
    if (!fc_skip_sml) chk("sb_sml_fcount", {16'd0, fc_sml}, 32'(mfc_sml));
  endtask

  task automatic wait_sml(input int x, input int y);
    int g = 0;
    while (!(dx_sml == 10'(x) && dy_sml == 10'(y)) && g < 2000) begin
      tick();
      g++;
    end
    chk("wait_sml_bound", 32'(g < 2000), 32'd1);
  endtask

  initial begin
    int hs_lo, hs_first, hs_last, bl_cnt, vs_lo, vb_cnt, vb_at, fs_cnt, g;
    rst_def = 1'b0;
    rst_sml = 1'b0;

    // Reset held 3 cycles: parked on the last pixel, blanked, syncs idle.
    repeat (3) begin
      tick();
      chk("rst_drawx", 32'(dx_def), 32'd799);
      chk("rst_drawy", 32'(dy_def), 32'd524);
      chk("rst_flags", {27'd0, bl_def, hs_def, vs_def, fs_def, vb_def}, 32'b01100);
      chk("rst_fcount", 32'(fc_def), 32'd0);
    end
    rst_def = 1'b1;
    rst_sml = 1'b1;
    tick();
    chk("rel_xy", {12'd0, dx_def, dy_def}, 32'd0);
    chk("rel_blank_fs", {30'd0, bl_def, fs_def}, 32'b11);
    chk("rel_fcount", 32'(fc_def), 32'd1);

    // One default-timing line from (0,0).
    hs_lo = 0; hs_first = -1; hs_last = -1; bl_cnt = 0;
    for (int c = 0; c < HT_D; c++) begin
      if (!hs_def) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(dx_def);
        hs_last = int'(dx_def);
      end
      if (bl_def) bl_cnt++;
      tick();
    end
    chk("line_hs_len", 32'(hs_lo), 32'd96);
    chk("line_hs_first", 32'(hs_first), 32'd656);
    chk("line_hs_last", 32'(hs_last), 32'd751);
    chk("line_blank_len", 32'(bl_cnt), 32'd640);
    chk("line_next_xy", {12'd0, dx_def, dy_def}, {12'd0, 10'd0, 10'd1});

    // One full frame on the shrunken raster.
    rst_sml = 1'b0;
    repeat (2) tick();
    rst_sml = 1'b1;
    tick();
    vs_lo = 0; vb_cnt = 0; vb_at = -1; fs_cnt = 0;
    for (int c = 0; c < HT_S * VT_S; c++) begin
      if (!vs_sml) vs_lo++;
      if (vb_sml) begin vb_cnt++; vb_at = c; end
      if (fs_sml) fs_cnt++;
      tick();
    end
    chk("frm_vs_len", 32'(vs_lo), 32'd50);
    chk("frm_vblank_cnt", 32'(vb_cnt), 32'd1);
    chk("frm_vblank_at", 32'(vb_at), 32'd250);
    chk("frm_fs_cnt", 32'(fs_cnt), 32'd1);
    chk("frm_next_fs", 32'(fs_sml), 32'd1);
    chk("frm_next_fcount", 32'(fc_sml), 32'd2);

    // Mid-frame reset on the shrunken raster: no sync activity while held.
    wait_sml(7, 5);
    rst_sml = 1'b0;
    repeat (3) begin
      tick();
      chk("mid_rst_sync", {30'd0, hs_sml, vs_sml}, 32'b11);
      chk("mid_rst_fs", 32'(fs_sml), 32'd0);
    end
    rst_sml = 1'b1;
    tick();
    chk("mid_rel_xy", {12'd0, dx_sml, dy_sml}, 32'd0);
    chk("mid_rel_fcount", 32'(fc_sml), 32'd1);

    // Frame counter preloaded to 65535 rolls to 0 on the next frame start.
    fc_skip_sml = 1'b1;
    force u_sml.frame_cnt_q = 16'hFFFF;
    wait_sml(HT_S - 1, VT_S - 1);
    chk("wrap_pre", 32'(fc_sml), 32'd65535);
    preload_sml = 1'b1;
    release u_sml.frame_cnt_q;
    tick();
    preload_sml = 1'b0;
    fc_skip_sml = 1'b0;
    chk("wrap_fcount", 32'(fc_sml), 32'd0);
    chk("wrap_fs", 32'(fs_sml), 32'd1);

    // Mid-line reset on the default raster, random point in the line.
    g = 0;
    hs_first = int'($urandom_range(600, 1));
    while (dx_def != 10'(hs_first) && g < 1000) begin tick(); g++; end
    chk("wait_def_bound", 32'(g < 1000), 32'd1);
    rst_def = 1'b0;
    repeat (int'($urandom_range(4, 2))) begin
      tick();
      chk("def_mid_rst_sync", {30'd0, hs_def, vs_def}, 32'b11);
    end
    rst_def = 1'b1;
    tick();
    chk("def_mid_rel", {dx_def, dy_def, 12'(fc_def)}, {10'd0, 10'd0, 12'd1});

    // Random free-run with occasional resets; the scoreboard checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(399, 0) == 0) rst_sml = ~rst_sml;
      if (!rst_sml && $urandom_range(3, 0) == 0) rst_sml = 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock, vga_clk (25.175 MHz pixel clock), and one reset, reset_n; reset is synchronous and active-low.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- vga_clk  in  1  pixel clock; all logic is rising-edge.
- reset_n  in  1  synchronous active-low reset.
- DrawX  out  10  current pixel column, 0..799.
- DrawY  out  10  current line, 0..524.
- blank  out  1  1 = visible pixel (draw enable), 0 = blanking; consumers gate RGB with it.
- hs  out  1  horizontal sync, active-low.
- vs  out  1  vertical sync, active-low.
- frame_start  out  1  one-cycle pulse while (DrawX,DrawY) = (0,0).
- vblank_start  out  1  one-cycle pulse while (DrawX,DrawY) = (0,480); game-logic update strobe.
- frame_count  out  16  frames started since reset, wraps.
REQ-003 Parameters SHALL be (name, default, meaning):
- H_VIS, 640, visible columns.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
REQ-004 All outputs SHALL be registered; no combinational path from reset_n to any output.

Function
REQ-005 H_TOTAL SHALL equal H_VIS+H_FP+H_SYNC+H_BP (800). V_TOTAL SHALL equal the sum of the vertical parameters (525).
REQ-006 DrawX SHALL increment by 1 every vga_clk cycle. At H_TOTAL-1 it SHALL wrap to 0 on the next cycle.
REQ-007 DrawY SHALL increment by 1 only on the cycle DrawX wraps. When DrawX and DrawY are both at their maximum, DrawY SHALL wrap to 0 on the same edge.
REQ-008 In every cycle, blank, hs, vs, frame_start and vblank_start SHALL correspond to the DrawX/DrawY presented in that same cycle (zero skew). Implement this by registering them from the next-state counter values.
REQ-009 blank SHALL be 1 if and only if DrawX < H_VIS and DrawY < V_VIS.
REQ-010 hs SHALL be 0 if and only if H_VIS+H_FP <= DrawX < H_VIS+H_FP+H_SYNC (656..751).
REQ-011 vs SHALL be 0 if and only if V_VIS+V_FP <= DrawY < V_VIS+V_FP+V_SYNC (490..491), for all columns of those lines.
REQ-012 frame_start SHALL be 1 only in the cycle where (0,0) is presented.
REQ-013 vblank_start SHALL be 1 only in the cycle where (0,V_VIS) is presented.
REQ-014 frame_count SHALL increment by 1, modulo 2^16, on the edge where the counters wrap from (799,524) to (0,0). The first frame after reset therefore shows 1. 65535 SHALL wrap to 0.
REQ-015 Counter comparisons SHALL use at least 10-bit unsigned arithmetic. No intermediate value may exceed 10 bits for the default parameters.

Reset
REQ-016 On any rising edge with reset_n = 0, the block SHALL load the following, regardless of the current count:
- DrawX = 799, DrawY = 524.
- blank = 0, hs = 1, vs = 1.
- frame_start = 0, vblank_start = 0.
- frame_count = 0.
REQ-017 The first rising edge with reset_n = 1 SHALL present (0,0) with blank = 1, frame_start = 1 and frame_count = 1.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately. No sync pulse or frame_start may be emitted while reset_n = 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset held 3 cycles, then released -> during reset (799,524,blank0,hs1,vs1); first cycle after release (0,0), blank1, frame_start1, frame_count1.
- Run 800 cycles from (0,0) -> hs low exactly for DrawX 656..751 (96 cycles); blank 1 for DrawX 0..639 only; DrawY becomes 1 at cycle 800.
- Run one full frame (420000 cycles) -> vs low for exactly 1600 cycles (DrawY 490..491); vblank_start once at (0,480); frame_start again at cycle 420000 with frame_count 2.
- Assert reset_n = 0 at (300,200), then release -> next cycle after release (0,0), frame_count 1, no hs/vs low pulse observed during reset.
- Force frame_count to 65535 (preload or 65535 frames) -> next wrap gives frame_count 0 with frame_start 1.
- Every cycle of a full frame -> scoreboard checks blank/hs/vs against REQ-009..011 computed from the same-cycle DrawX/DrawY (zero-skew check).
